mc_mem_responder: RTL and testbench

Unified instruction/data memory responder for the multicycle MIPS core. It sits on the memory side of the address/data bus that the multicycle controller drives during fetch (IorD=0), load and store (IorD=1, MemWrite). It accepts one request at a time, inserts a configurable number of wait states, and signals completion with a one-cycle `ready` pulse. The controller can therefore run against slow memory as well as single-cycle memory.

---
 rtl/mc_mem_responder.sv | 124 ++++++++++++
 tb/tb_mc_mem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_mem_responder.sv
// Unified instruction/data memory responder with LATENCY wait states and a one-cycle ready pulse.
// Optional misaligned-access checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mc_mem_responder #(
  parameter int AW      = 6,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic [31:0]     mem_q [2**AW];

  logic            acc_we_d;
  logic [AW+1:0]   acc_addr_d;
  logic [31:0]     acc_wdata_d;
  logic [AW-1:0]   idx_d;
  logic            enter_resp_d;
  logic            misalign_d;

  // With zero latency the access happens on the accept edge, so use live inputs in IDLE.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we_d    = we;
      acc_addr_d  = addr[AW+1:0];
      acc_wdata_d = wdata;
    end else begin
      acc_we_d    = we_q;
      acc_addr_d  = addr_q;
      acc_wdata_d = wdata_q;
    end
    idx_d = acc_addr_d[AW+1:2];
    case (state_q)
      S_IDLE:  enter_resp_d = req && (LATENCY == 0);
      S_WAIT:  enter_resp_d = (cnt_q == 4'd1);
      default: enter_resp_d = 1'b0;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_d = (acc_addr_d[1:0] != 2'b00);
`else
  assign misalign_d = 1'b0;
`endif

  wire unused_addr_bits = &{1'b0, addr[31:AW+2], acc_addr_d[1:0]};

  // Control FSM, request capture and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= {(AW+2){1'b0}};
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
            if (LATENCY == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(LATENCY);
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          err_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
      if (enter_resp_d) begin
        err_q <= misalign_d;
        if (!acc_we_d) begin
          rdata_q <= misalign_d ? 32'd0 : mem_q[idx_d];
        end
      end
    end
  end

  // Array write; reset on the completing edge discards the store.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp_d && acc_we_d && !misalign_d) begin
      mem_q[idx_d] <= acc_wdata_d;
    end
  end

  assign rdata = rdata_q;
  assign ready = (state_q == S_RESP);
  assign err   = err_q;

endmodule

// File: tb/tb_mc_mem_responder.sv
// Self-checking bench for mc_mem_responder: vector table, hand-written corner sequences,
// and randomized accesses checked against a transaction-level memory model.
module tb_mc_mem_responder;

  localparam int LAT = 2;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata, rdata;
  logic        ready, err;
  logic        req0, we0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ready0, err0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_mem_responder #(.AW(6), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err)
  );

  mc_mem_responder #(.AW(6), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .err(err0)
  );

  // Reference model: word array plus the last read response value.
  logic [31:0] mmem [64];
  logic [31:0] mlast = 32'd0;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void mpredict(input bit w, input logic [31:0] a, input logic [31:0] d,
                                   output logic [31:0] er, output bit ee);
    bit mis;
    int i;
    mis = ALIGN && (a[1:0] != 2'b00);
    i   = int'(a[7:2]);
    ee  = mis;
    if (w) begin
      if (!mis) mmem[i] = d;
      er = mlast;
    end else begin
      er    = mis ? 32'd0 : mmem[i];
      mlast = er;
    end
  endfunction

  // One access on the LATENCY=2 instance, started from an IDLE cycle.
  task automatic acc2(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input bit exp_err, input string nm);
    int n;
    req = 1'b1; we = w; addr = a; wdata = d;
    step();
    req = 1'b0;
    n = 1;
    while (!ready && n < 20) begin
      step();
      n++;
    end
    check({nm, " latency"}, 32'(n), 32'(LAT + 1));
    check({nm, " rdata"}, rdata, exp_rd);
    check({nm, " err"}, {31'd0, err}, {31'd0, exp_err});
    step();
    check({nm, " pulse"}, {31'd0, ready}, 32'd0);
  endtask

  task automatic macc(input bit w, input logic [31:0] a, input logic [31:0] d, input string nm);
    logic [31:0] er;
    bit ee;
    mpredict(w, a, d, er, ee);
    acc2(w, a, d, er, ee, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] m4, r13, er;
    bit ee;
    int nresp, last_c, cnt;
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
    step(); step();
    check("reset ready", {31'd0, ready}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset rdata0", rdata0, 32'd0);
    reset = 1'b0;
    step();

    m4  = ALIGN ? 32'hDEADBEEF : 32'hFFFFFFFF;
    r13 = ALIGN ? 32'h00000000 : 32'hFFFFFFFF;
    tbl[0] = '{1'b1, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1] = '{1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 32'h104, 32'h12345678, 32'hDEADBEEF, 1'b0};
    tbl[3] = '{1'b0, 32'h004, 32'h0,        32'h12345678, 1'b0};
    tbl[4] = '{1'b1, 32'h011, 32'hFFFFFFFF, 32'h12345678, ALIGN};
    tbl[5] = '{1'b0, 32'h010, 32'h0,        m4,           1'b0};
    tbl[6] = '{1'b0, 32'h013, 32'h0,        r13,          ALIGN};
    tbl[7] = '{1'b1, 32'h000, 32'h1,        r13,          1'b0};
    tbl[8] = '{1'b1, 32'h004, 32'h2,        r13,          1'b0};
    tbl[9] = '{1'b1, 32'h008, 32'h55555555, r13,          1'b0};
    for (int i = 0; i < 10; i++) begin
      mpredict(tbl[i].w, tbl[i].a, tbl[i].d, er, ee);
      acc2(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp_rd, tbl[i].exp_err, $sformatf("vec%0d", i));
    end

    // Held request, alternating reads of word 0 and word 1.
    req = 1'b1; we = 1'b0; addr = 32'h0;
    nresp = 0; last_c = 0;
    for (int c = 1; c <= 24 && nresp < 4; c++) begin
      step();
      if (ready) begin
        check($sformatf("held rdata%0d", nresp), rdata, (nresp % 2 == 0) ? 32'h1 : 32'h2);
        if (nresp == 0) check("held first", 32'(c), 32'(LAT + 1));
        else            check("held period", 32'(c - last_c), 32'(LAT + 2));
        last_c = c;
        nresp++;
        addr = (nresp % 2 == 1) ? 32'h4 : 32'h0;
        if (nresp == 4) req = 1'b0;
      end
    end
    check("held count", 32'(nresp), 32'd4);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ready) cnt++;
    end
    check("held drop", 32'(cnt), 32'd0);
    mlast = 32'h2;

    // Reset one cycle after accept aborts the write.
    req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'hAAAAAAAA;
    step();
    req = 1'b0; reset = 1'b1;
    step();
    check("rstwait ready", {31'd0, ready}, 32'd0);
    check("rstwait rdata", rdata, 32'd0);
    check("rstwait err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    mlast = 32'd0;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (ready) cnt++;
    end
    check("rstwait noready", 32'(cnt), 32'd0);
    macc(1'b0, 32'h8, 32'h0, "rstwait read");

    // Reset on the edge that would enter RESP.
    req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'hBBBBBBBB;
    step();
    req = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("rstedge ready", {31'd0, ready}, 32'd0);
    reset = 1'b0;
    mlast = 32'd0;
    step();
    check("rstedge idle", {31'd0, ready}, 32'd0);
    macc(1'b0, 32'h8, 32'h0, "rstedge read");

    // Fill the array, then random traffic against the model.
    for (int i = 0; i < 64; i++) macc(1'b1, 32'(i * 4), $urandom, $sformatf("fill%0d", i));
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      macc(1'($urandom_range(1)), a, $urandom, $sformatf("rnd%0d", i));
    end

    // Zero-latency instance: single write, then held reads.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hCAFEF00D;
    step();
    check("l0 write ready", {31'd0, ready0}, 32'd1);
    req0 = 1'b0;
    step();
    check("l0 write pulse", {31'd0, ready0}, 32'd0);
    req0 = 1'b1; we0 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step();
      check($sformatf("l0 held ready%0d", c), {31'd0, ready0}, (c % 2 == 1) ? 32'd1 : 32'd0);
      if (ready0) check($sformatf("l0 held rdata%0d", c), rdata0, 32'hCAFEF00D);
      if (c == 7) req0 = 1'b0;
    end
    check("l0 err", {31'd0, err0}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
